rr_arb4: RTL and testbench
==========================

RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of each requester and of the output channel.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  4  per-requester request; bit i = requester i has data valid.
REQ-005 SHALL have port last  input  4  per-requester end-of-packet flag, qualified by req[i].
REQ-006 SHALL have ports d0, d1, d2, d3  input  WIDTH each  requester data.
REQ-007 SHALL have port out_ready  input  1  downstream accepts current beat.
REQ-008 SHALL have port y  output  WIDTH  selected data.
REQ-009 SHALL have port out_valid  output  1  y carries a valid beat.
REQ-010 SHALL have port out_last  output  1  last[sel] of the granted requester, gated by out_valid.
REQ-011 SHALL have port sel  output  2  binary index of the granted requester (mux select).
REQ-012 SHALL have port gnt  output  4  one-hot grant; all-zero when idle.
REQ-013 SHALL have port ack  output  4  ack[i] = gnt[i] & req[i] & out_ready; requester i advances on ack[i].

Function
REQ-014 SHALL implement states IDLE and BUSY.
REQ-015 In IDLE, if req != 0, SHALL register a grant to the first requester with req set, searching ptr+1, ptr+2, ptr+3, ptr (mod 4), and enter BUSY on the next edge (1-cycle arbitration latency).
REQ-016 In IDLE, if req == 0, SHALL remain in IDLE; gnt = 0, out_valid = 0.
REQ-017 In BUSY, y SHALL equal d[sel] combinationally, out_valid = req[sel], and out_last = req[sel] & last[sel].
REQ-018 A beat SHALL transfer in any BUSY cycle where out_valid & out_ready.
REQ-019 On a transfer with out_last = 1, SHALL return to IDLE, set ptr = sel, and clear gnt on the next edge.
REQ-020 In BUSY, deassertion of req[sel] without last SHALL hold the grant (packet lock); out_valid drops and no beat transfers.
REQ-021 Requests from non-granted requesters during BUSY SHALL have no effect until IDLE is re-entered.
REQ-022 Exactly one idle cycle SHALL separate consecutive packets (no back-to-back re-grant).
REQ-023 A single-beat packet (req & last together) SHALL complete in one BUSY cycle when out_ready = 1.
REQ-024 When out_valid = 0, y SHALL still equal d[sel] in BUSY and SHALL be 0 in IDLE.
REQ-025 ptr arithmetic SHALL be 2-bit modulo 4; wrap from 3 to 0 is required.

Reset
REQ-026 Asserting reset SHALL immediately force state = IDLE, ptr = 3 (so requester 0 has first priority), gnt = 0, sel = 0, out_valid = 0, out_last = 0, ack = 0, y = 0.
REQ-027 Reset asserted mid-packet SHALL abort the packet with no further ack; arbitration restarts from requester 0 after release.

Structure
REQ-028 Package rr_arb4_pkg SHALL hold the state enum (IDLE, BUSY) and constant NREQ = 4.
REQ-029 Sub-module rr_pick4 SHALL implement the combinational rotating-priority picker (inputs req, ptr; outputs one-hot winner, 2-bit index, any).
REQ-030 State, ptr, gnt and sel SHALL be the only registers; y, out_valid, out_last and ack are combinational from them.

Verification
REQ-031 Reset, then req=0001, last=0001, d0=4'hA, out_ready=1 -> gnt=0001 one cycle later, y=A, out_valid=1, ack=0001 for one cycle, IDLE next.
REQ-032 req=1111, all last=1, out_ready=1 held -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-033 Requester 2 sends 3 beats (last on third), out_ready toggled 1,0,1,1 -> exactly 3 acks, gnt=0100 throughout, requester 1 requesting meanwhile not granted until after.
REQ-034 ptr=3 after a grant to requester 3, then req=1001 -> requester 0 granted (wrap-around).
REQ-035 Mid-packet req[sel] dropped for 2 cycles -> out_valid=0, gnt unchanged, no ack; resumes when req returns.
REQ-036 Reset asserted in BUSY mid-packet -> gnt=0, out_valid=0 immediately; after release with req=1111, requester 0 is granted first.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the rr_arb4 round-robin packet arbiter.
// Imported by the picker and the top level.
package rr_arb4_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker for four requesters.
// Searches ptr+1, ptr+2, ptr+3, ptr (mod 4) and returns the first hit.
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] win,
  output logic [1:0]      idx,
  output logic            any
);

  logic [1:0] c;
  logic       found;

  // Walk the rotated priority order; the first requester seen wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    c     = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      c = ptr + 2'(k);
      if (!found && req[c]) begin
        found  = 1'b1;
        win[c] = 1'b1;
        idx    = c;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_arb4.sv
// Four-way round-robin packet arbiter with packet lock.
// A grant is held from the first beat until the beat flagged last.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             out_last,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic [3:0]       ack
);

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] sel_n;
  logic [3:0] gnt_n;
  logic [3:0] win;
  logic [1:0] idx;
  logic       any;
  logic       busy;
  logic [WIDTH-1:0] dsel;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .idx (idx),
    .any (any)
  );

  // State, pointer and grant registers; ptr=3 gives requester 0 first turn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd3;
      gnt   <= '0;
      sel   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
    end
  end

  // Next-state: grant in IDLE, release on the last accepted beat.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    sel_n   = sel;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = BUSY;
          gnt_n   = win;
          sel_n   = idx;
        end
      end
      BUSY: begin
        if (out_last && out_ready) begin
          state_n = IDLE;
          ptr_n   = sel;
          gnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Data mux driven by the registered select.
  always_comb begin
    dsel = '0;
    unique case (sel)
      2'd0: dsel = d0;
      2'd1: dsel = d1;
      2'd2: dsel = d2;
      2'd3: dsel = d3;
      default: dsel = '0;
    endcase
  end

  assign busy      = (state == BUSY);
  assign y         = busy ? dsel : '0;
  assign out_valid = busy & req[sel];
  assign out_last  = out_valid & last[sel];
  assign ack       = gnt & req & {4{out_ready}};

endmodule

// File: tb/tb_rr_arb4.sv
// Directed testbench for rr_arb4.
// Each scenario task drives vectors and checks hand-computed results.
module tb_rr_arb4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] d0, d1, d2, d3;
  logic       out_ready;
  logic [3:0] y;
  logic       out_valid;
  logic       out_last;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [3:0] ack;

  int total;
  int bad;

  rr_arb4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_ready (out_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_last  (out_last),
    .sel       (sel),
    .gnt       (gnt),
    .ack       (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    reset = 1'b1;
    #1;
    total++;
    if ({gnt, sel, out_valid, out_last, ack, y} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b sel=%0d ov=%b ol=%b ack=%b y=%h want all zero",
               gnt, sel, out_valid, out_last, ack, y);
    end
    tick();
    reset = 1'b0;
    req = 4'b0000;
    #1;
    total++;
    if ({gnt, out_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_release: got gnt=%b ov=%b want 0000 0", gnt, out_valid);
    end
  endtask

  task automatic test_single();
    req = 4'b0001; last = 4'b0001; out_ready = 1'b1;
    #1;
    total++;
    if ({gnt, out_valid, y} !== 9'b0) begin
      bad++;
      $display("FAIL single_idle: got gnt=%b ov=%b y=%h want 0000 0 0", gnt, out_valid, y);
    end
    tick();
    total++;
    if ({gnt, y, out_valid, out_last, ack} !== {4'b0001, 4'hA, 1'b1, 1'b1, 4'b0001}) begin
      bad++;
      $display("FAIL single_beat: got gnt=%b y=%h ov=%b ol=%b ack=%b want 0001 a 1 1 0001",
               gnt, y, out_valid, out_last, ack);
    end
    tick();
    req = 4'b0000;
    #1;
    total++;
    if ({gnt, out_valid, ack} !== 9'b0) begin
      bad++;
      $display("FAIL single_done: got gnt=%b ov=%b ack=%b want idle", gnt, out_valid, ack);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [5];
    logic [3:0] ey [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ey = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    do_reset();
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (gnt !== 4'b0000) begin
        bad++;
        $display("FAIL rr_gap%0d: got gnt=%b want 0000", i, gnt);
      end
      tick();
      total++;
      if ({gnt, ack, y, out_last} !== {eg[i], eg[i], ey[i], 1'b1}) begin
        bad++;
        $display("FAIL rr_grant%0d: got gnt=%b ack=%b y=%h ol=%b want %b %b %h 1",
                 i, gnt, ack, y, out_last, eg[i], eg[i], ey[i]);
      end
      tick();
    end
    req = 4'b0000;
    #1;
  endtask

  task automatic test_multi_beat();
    logic       rdy [4];
    logic [3:0] lst [4];
    logic [3:0] eack [4];
    int acks;
    rdy  = '{1'b1, 1'b0, 1'b1, 1'b1};
    lst  = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};
    eack = '{4'b0100, 4'b0000, 4'b0100, 4'b0100};
    acks = 0;
    do_reset();
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    tick();
    req = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      out_ready = rdy[i];
      last = lst[i];
      #1;
      if (ack[2]) acks++;
      total++;
      if ({gnt, ack, out_valid, y} !== {4'b0100, eack[i], 1'b1, 4'hC}) begin
        bad++;
        $display("FAIL multi_beat%0d: got gnt=%b ack=%b ov=%b y=%h want 0100 %b 1 c",
                 i, gnt, ack, out_valid, y, eack[i]);
      end
      tick();
    end
    total++;
    if (acks != 3) begin
      bad++;
      $display("FAIL multi_ack_count: got %0d want 3", acks);
    end
    req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
    #1;
    total++;
    if (gnt !== 4'b0000) begin
      bad++;
      $display("FAIL multi_gap: got gnt=%b want 0000", gnt);
    end
    tick();
    total++;
    if ({gnt, sel} !== {4'b0010, 2'd1}) begin
      bad++;
      $display("FAIL multi_next: got gnt=%b sel=%0d want 0010 1", gnt, sel);
    end
    last = 4'b0010;
    tick();
    req = 4'b0000; last = 4'b0000;
    #1;
  endtask

  task automatic test_wrap();
    req = 4'b1000; last = 4'b1000; out_ready = 1'b1;
    tick();
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_g3: got gnt=%b want 1000", gnt);
    end
    tick();
    req = 4'b1001; last = 4'b0000;
    tick();
    total++;
    if ({gnt, y} !== {4'b0001, 4'hA}) begin
      bad++;
      $display("FAIL wrap_g0: got gnt=%b y=%h want 0001 a", gnt, y);
    end
    req = 4'b0001; last = 4'b0001;
    tick();
    req = 4'b0000; last = 4'b0000;
    #1;
  endtask

  task automatic test_lock();
    req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
    tick();
    total++;
    if ({gnt, out_valid, ack} !== {4'b0010, 1'b1, 4'b0010}) begin
      bad++;
      $display("FAIL lock_start: got gnt=%b ov=%b ack=%b want 0010 1 0010", gnt, out_valid, ack);
    end
    tick();
    req = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({gnt, out_valid, ack, y} !== {4'b0010, 1'b0, 4'b0000, 4'hB}) begin
        bad++;
        $display("FAIL lock_hold%0d: got gnt=%b ov=%b ack=%b y=%h want 0010 0 0000 b",
                 i, gnt, out_valid, ack, y);
      end
      tick();
    end
    req = 4'b0010; last = 4'b0010;
    #1;
    total++;
    if ({out_valid, out_last, ack} !== {1'b1, 1'b1, 4'b0010}) begin
      bad++;
      $display("FAIL lock_resume: got ov=%b ol=%b ack=%b want 1 1 0010", out_valid, out_last, ack);
    end
    tick();
    req = 4'b0000; last = 4'b0000;
    #1;
    total++;
    if (gnt !== 4'b0000) begin
      bad++;
      $display("FAIL lock_release: got gnt=%b want 0000", gnt);
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    tick();
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL rmid_grant: got gnt=%b want 0100", gnt);
    end
    tick();
    reset = 1'b1;
    #1;
    total++;
    if ({gnt, out_valid, ack, y} !== 13'b0) begin
      bad++;
      $display("FAIL rmid_abort: got gnt=%b ov=%b ack=%b y=%h want zero", gnt, out_valid, ack, y);
    end
    tick();
    reset = 1'b0;
    req = 4'b1111; last = 4'b1111;
    #1;
    tick();
    total++;
    if ({gnt, sel, y} !== {4'b0001, 2'd0, 4'hA}) begin
      bad++;
      $display("FAIL rmid_restart: got gnt=%b sel=%0d y=%h want 0001 0 a", gnt, sel, y);
    end
    tick();
    req = 4'b0000;
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    req = '0;
    last = '0;
    out_ready = 1'b0;
    d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_multi_beat();
    test_wrap();
    test_lock();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
